game_settings_sequencer: RTL

- Sits between the board buttons/switches and game_controller and sequences its configuration and control inputs.
- Conditions the raw start/serve buttons: 2-FF synchroniser, debounce, one-cycle pulse.
- Latches the switch settings (mode, max_score, speed, serve type, angle, bat size) only while the game is in its start state, and freezes them during play.
- After a win, imposes a serve hold-off so the press that ended the rally cannot immediately reset the game.

---
 rtl/game_pkg.sv | 35 +++
 rtl/button_debouncer.sv | 60 ++++++
 rtl/game_settings_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types for the game settings sequencer: FSM states,
// mode and max-score codes, and the latched settings bundle.
package game_pkg;

    typedef enum logic [1:0] {
        OPEN   = 2'b00,
        LOCKED = 2'b01,
        HOLD   = 2'b10,
        ARMED  = 2'b11
    } seq_state_e;

    typedef enum logic [1:0] {
        MODE_TENNIS   = 2'b00,
        MODE_SOCCER   = 2'b01,
        MODE_SQUASH   = 2'b10,
        MODE_PRACTICE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        MAX_10 = 2'b00,
        MAX_15 = 2'b01,
        MAX_20 = 2'b10,
        MAX_30 = 2'b11
    } max_score_e;

    typedef struct packed {
        mode_e      mode;
        max_score_e max_score;
        logic       ball_speed;
        logic       serve_type;
        logic       angle;
        logic       bat_size;
    } settings_t;

endpackage

// File: rtl/button_debouncer.sv
// Conditions one raw button: 2-FF synchroniser, stability counter,
// and a registered one-cycle pulse on the debounced 0->1 edge.
// Ports: clk, rst (async high), btn_raw in; level, rise out.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            prev_q;
    logic            rise_q, rise_d;

    // Counter only runs while the synchronised input disagrees with
    // the debounced level, so any bounce shorter than the window
    // clears it and never reaches the switch-over point.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = level_q & ~prev_q;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/game_settings_sequencer.sv
// Sequences game_controller config/control: debounced start/serve
// pulses, switch settings latched only in OPEN, post-win serve hold-off.
// Ports: clk, rst, btn_*, sw_*, start_state, p*_win in;
// latched settings, start/serve pulses, cfg_locked, holdoff out.
module game_settings_sequencer
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18,
    parameter int HOLDOFF_CYCLES  = 50000000,
    parameter int HO_W            = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_serve,
    input  logic [1:0] sw_mode,
    input  logic [1:0] sw_max_score,
    input  logic       sw_ball_speed,
    input  logic       sw_serve_type,
    input  logic       sw_angle,
    input  logic       sw_bat_size,
    input  logic       start_state,
    input  logic       p1_win,
    input  logic       p2_win,
    output logic [1:0] mode,
    output logic [1:0] max_score,
    output logic       ball_speed,
    output logic       serve_type,
    output logic       angle,
    output logic       bat_size,
    output logic       start,
    output logic       serve,
    output logic       cfg_locked,
    output logic       holdoff
);

    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

    logic start_rise, serve_rise;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_W           (DB_W)
    ) u_db_start (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_start),
        .level  (),
        .rise   (start_rise)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_W           (DB_W)
    ) u_db_serve (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_serve),
        .level  (),
        .rise   (serve_rise)
    );

    seq_state_e      state_q, state_d;
    settings_t       cfg_q, cfg_d;
    logic [HO_W-1:0] ho_cnt_q, ho_cnt_d;
    logic            start_ok;

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        ho_cnt_d   = ho_cnt_q;
        start_ok   = 1'b0;
        serve      = 1'b0;
        cfg_locked = 1'b1;
        holdoff    = 1'b0;
        unique case (state_q)
            OPEN: begin
                cfg_d.mode       = mode_e'(sw_mode);
                cfg_d.max_score  = max_score_e'(sw_max_score);
                cfg_d.ball_speed = sw_ball_speed;
                cfg_d.serve_type = sw_serve_type;
                cfg_d.angle      = sw_angle;
                cfg_d.bat_size   = sw_bat_size;
                cfg_locked       = 1'b0;
                // A start press outside the controller's START is dropped.
                start_ok         = start_rise & start_state;
                serve            = serve_rise;
                if (start_ok) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                serve = serve_rise;
                // Win outranks a simultaneous return to START.
                if (p1_win | p2_win) begin
                    state_d  = HOLD;
                    ho_cnt_d = '0;
                end else if (start_state) begin
                    state_d = OPEN;
                end
            end
            HOLD: begin
                holdoff = 1'b1;
                if (ho_cnt_q == HO_LAST) begin
                    state_d = ARMED;
                end else begin
                    ho_cnt_d = ho_cnt_q + 1'b1;
                end
            end
            ARMED: begin
                serve = serve_rise;
                if (start_state) begin
                    state_d = OPEN;
                end
            end
            default: state_d = OPEN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= OPEN;
            cfg_q    <= '0;
            ho_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            ho_cnt_q <= ho_cnt_d;
        end
    end

    assign start      = start_ok;
    assign mode       = cfg_q.mode;
    assign max_score  = cfg_q.max_score;
    assign ball_speed = cfg_q.ball_speed;
    assign serve_type = cfg_q.serve_type;
    assign angle      = cfg_q.angle;
    assign bat_size   = cfg_q.bat_size;

endmodule
